// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial addition controller around an external 1-bit full adder.
// Operands are fed to the adder LSB first, one bit per cycle. The carry is registered
// and fed back, and the sum bits are assembled into a parallel result.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_init,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_sum,
    input  logic             fa_co,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             accept_c;
    logic             last_c;

    // The adder is combinational, so its inputs come straight from the shift registers during RUN.
    assign fa_a  = (state_q == RUN) & a_sr[0];
    assign fa_b  = (state_q == RUN) & b_sr[0];
    assign fa_ci = (state_q == RUN) & carry_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. DONE always lasts exactly one cycle.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        last_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture operands on acceptance, then shift one bit through the adder per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            result  <= '0;
            cout    <= 1'b0;
        end else if (accept_c) begin
            a_sr    <= op_a;
            b_sr    <= op_b;
            carry_q <= cin_init;
            cnt_q   <= '0;
            result  <= '0;
            cout    <= 1'b0;
        end else if (state_q == RUN) begin
            result  <= {fa_sum, result[WIDTH-1:1]};
            carry_q <= fa_co;
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            cnt_q   <= CW'(cnt_q + 1'b1);
            if (last_c) begin
                cout <= fa_co;
            end
        end
    end

    // Status flags are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d == RUN);
            done <= (state_d == DONE);
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Signed overflow: the carry into the MSB differs from the carry out of the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (accept_c) begin
            ovf <= 1'b0;
        end else if (last_c) begin
            ovf <= fa_ci ^ fa_co;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl (WIDTH=8) with a behavioural full adder on the fa_* ports.
// A timeline model predicts every output each cycle; directed cases pin literal results.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin_init;
    logic         fa_a, fa_b, fa_ci, fa_sum, fa_co;
    logic [W-1:0] result;
    logic         cout, busy, done;
    logic         ovf;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int cyc = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .cin_init(cin_init), .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci),
        .fa_sum(fa_sum), .fa_co(fa_co), .result(result), .cout(cout),
        .busy(busy), .done(done)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    // Behavioural full adder.
    assign fa_sum = fa_a ^ fa_b ^ fa_ci;
    assign fa_co  = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: m_t = -1 when idle, 0..W-1 edges into a run, W for the done cycle.
    int           m_t;
    logic [W-1:0] m_a, m_b, m_res;
    logic         m_cin, m_cout, m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= -1; m_a <= '0; m_b <= '0; m_cin <= 1'b0;
            m_res <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (m_t == -1) begin
                if (start) begin
                    m_t <= 0; m_a <= op_a; m_b <= op_b; m_cin <= cin_init;
                    m_res <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
                end
            end else if (m_t < int'(W)) begin
                m_t <= m_t + 1;
                if (m_t == int'(W) - 1) begin
                    int s, ss;
                    s  = int'(m_a) + int'(m_b) + int'(m_cin);
                    ss = int'($signed(m_a)) + int'($signed(m_b)) + int'(m_cin);
                    m_res  <= W'(s);
                    m_cout <= s[W];
                    m_ovf  <= (ss > 127) || (ss < -128);
                end
            end else begin
                m_t <= -1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic eb_a, eb_b, eb_c;
        int   mask, lo;
        eb_a = 1'b0; eb_b = 1'b0; eb_c = 1'b0;
        if (m_t >= 0 && m_t < int'(W)) begin
            mask = (1 << m_t) - 1;
            lo   = (int'(m_a) & mask) + (int'(m_b) & mask) + int'(m_cin);
            eb_a = m_a[m_t];
            eb_b = m_b[m_t];
            eb_c = ((lo >> m_t) & 1) != 0;
        end
        chk("busy", 32'(busy), 32'(m_t >= 0 && m_t < int'(W)));
        chk("done", 32'(done), 32'(m_t == int'(W)));
        chk("fa_a", 32'(fa_a), 32'(eb_a));
        chk("fa_b", 32'(fa_b), 32'(eb_b));
        chk("fa_ci", 32'(fa_ci), 32'(eb_c));
        if (m_t == -1 || m_t == int'(W)) begin
            chk("result", 32'(result), 32'(m_res));
            chk("cout", 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
            chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
        end
        if (done) n_done++;
    end

    // One addition from idle: pulse start, wait for done, check latency and literal result.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] er, input logic ec, input string nm);
        int n;
        @(posedge clk); #1;
        op_a = a; op_b = b; cin_init = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'd9);
        chk({nm, "_result"}, 32'(result), 32'(er));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
    endtask

    initial begin
        int d0, last, gaps_ok, nd;
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin_init = 1'b0;
        #12;
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fa", 32'({fa_a, fa_b, fa_ci}), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_add(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, "add05_03");
        do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "addFF_01");
        do_add(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "cin_only");

        // Mid-run start and operand changes must be ignored.
        @(posedge clk); #1;
        d0 = n_done;
        op_a = 8'h12; op_b = 8'h34; cin_init = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1; op_a = 8'hFF; op_b = 8'hFF; cin_init = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("midrun_result", 32'(result), 32'h46);
        chk("midrun_done_cnt", 32'(n_done - d0), 32'd1);

        // Reset in the middle of a run aborts it without a done pulse.
        d0 = n_done;
        op_a = 8'h55; op_b = 8'h0F; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1; rst_n = 1'b0;
        #2;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_fa", 32'({fa_a, fa_b, fa_ci}), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        do_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "add10_20");

        do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "add7F_01");
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf_7F_01", 32'(ovf), 32'd1);
`endif
        do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "addFF_01b");
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf_FF_01", 32'(ovf), 32'd0);
`endif

        // start held high: one addition every W+2 cycles.
        @(posedge clk); #1;
        op_a = 8'h21; op_b = 8'h42; cin_init = 1'b1; start = 1'b1;
        last = -1; gaps_ok = 1; nd = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) begin
                nd++;
                if (result !== 8'h64) gaps_ok = 0;
                if (last >= 0 && (i - last) != 10) gaps_ok = 0;
                last = i;
            end
        end
        start = 1'b0;
        chk("b2b_done_cnt", 32'(nd), 32'd3);
        chk("b2b_spacing_result", 32'(gaps_ok), 32'd1);
        repeat (15) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, cycles=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that drives the single-bit full adder stage (a, b, ci in; sum, co out). It loads two WIDTH-bit operands and feeds the adder one bit per cycle, LSB first. The adder's carry-out is registered and fed back as the next carry-in, and the sum bits are collected into a parallel result. It sits directly around the full adder and is the sequential consumer of its sum/co outputs.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin an addition; sampled only in IDLE
- op_a  input  WIDTH  operand A, captured when start is accepted
- op_b  input  WIDTH  operand B, captured when start is accepted
- cin_init  input  1  initial carry-in, captured when start is accepted
- fa_a  output  1  bit of A driven to the full adder
- fa_b  output  1  bit of B driven to the full adder
- fa_ci  output  1  carry driven to the full adder
- fa_sum  input  1  full adder sum, combinational from fa_a/fa_b/fa_ci
- fa_co  input  1  full adder carry-out, combinational
- result  output  WIDTH  assembled sum; held until the next accepted start
- cout  output  1  final carry-out; held with result
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse in DONE
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on start=1:
  - Load a_sr ← op_a and b_sr ← op_b.
  - Set carry_q ← cin_init and bit count ← 0.
  - Clear result to 0.
- RUN:
  - fa_a = a_sr[0], fa_b = b_sr[0], fa_ci = carry_q (combinational).
  - Each edge: result ← {fa_sum, result[WIDTH-1:1]}; carry_q ← fa_co; a_sr and b_sr shift right by 1; count increments.
  - When count = WIDTH-1 on an edge: cout ← fa_co, then → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE unconditionally.
- fa_a, fa_b and fa_ci are driven 0 in IDLE and DONE.
- start is ignored in RUN and DONE. No queuing and no error flag.
- Operands are captured at acceptance, so op_a, op_b and cin_init may change freely afterward.
- Counter is $clog2(WIDTH)+1 bits wide. It never wraps within a run.
- Arithmetic: {cout, result} = op_a + op_b + cin_init, unsigned, WIDTH+1 bits.

## Timing
- Reset (async assert, sync release): state=IDLE; result=0, cout=0, busy=0, done=0, fa_a/fa_b/fa_ci=0, ovf=0; all internal registers 0.
- Reset mid-RUN aborts the operation. The partial result is discarded and outputs go to reset values.
- start sampled high at edge E0 → busy high from E0 through E(WIDTH).
- done high in the cycle after edge E(WIDTH), i.e. WIDTH+1 cycles after acceptance.
- result and cout are valid when done rises and stay stable until the next accepted start.
- Back-to-back: start held high continuously → a new operation is accepted on the edge leaving DONE→IDLE+1. Throughput is one addition per WIDTH+2 cycles.
- The full adder is purely combinational and is settled within the same cycle. No adder pipeline latency is allowed.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Port ovf exists.
  - On the final RUN edge, ovf ← fa_ci XOR fa_co (carry into MSB XOR carry out of MSB).
  - ovf is held with result and cleared on start acceptance and on reset.
- SERIAL_ADDER_OVF_EN undefined: port ovf and its logic are absent. All other behaviour is identical.

## Test plan
The bench instantiates a behavioural full adder on the fa_* ports. All cases use WIDTH=8.
- op_a=8'h05, op_b=8'h03, cin_init=0, start one cycle → done pulses exactly 9 cycles after acceptance; result=8'h08, cout=0.
- op_a=8'hFF, op_b=8'h01, cin_init=0 → result=8'h00, cout=1. Also op_a=8'h00, op_b=8'h00, cin_init=1 → result=8'h01, cout=0.
- Mid-operation changes: start pulsed again at cycle 3 of RUN, and op_a/op_b changed → ignored; first result unchanged, and only one done pulse occurs.
- rst_n asserted at RUN cycle 4, then released → all outputs 0, state IDLE, no done pulse. A subsequent 8'h10+8'h20 gives 8'h30.
- With SERIAL_ADDER_OVF_EN defined:
  - 8'h7F+8'h01 → result=8'h80, cout=0, ovf=1.
  - 8'hFF+8'h01 → ovf=0.
- start held high for 30 cycles with fixed operands → done pulses every 10 cycles, with a correct result each time.
